// File: rtl/prco_decode_stage_pkg.sv
// Shared PRCO ISA definitions: opcode constants, control-bundle layout,
// skid-buffer states and the opcode decode table.
package prco_decode_stage_pkg;

    localparam int OPC_W = 8;

    localparam logic [OPC_W-1:0] OP_NOP  = 8'h00;
    localparam logic [OPC_W-1:0] OP_MOVI = 8'h01;
    localparam logic [OPC_W-1:0] OP_MOV  = 8'h02;
    localparam logic [OPC_W-1:0] OP_ADD  = 8'h03;
    localparam logic [OPC_W-1:0] OP_LW   = 8'h04;
    localparam logic [OPC_W-1:0] OP_SW   = 8'h05;

    typedef struct packed {
        logic reg_we;
        logic req_alu;
        logic req_ram;
        logic mem_we;
        logic illegal;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_FULL
    } buf_state_e;

    // Unknown opcodes get an all-zero bundle but are flagged, never dropped.
    function automatic ctrl_t decode_ctrl(input logic [OPC_W-1:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_NOP:  c = '0;
            OP_MOVI: c.reg_we = 1'b1;
            OP_MOV:  begin c.reg_we = 1'b1; c.req_alu = 1'b1; end
            OP_ADD:  begin c.reg_we = 1'b1; c.req_alu = 1'b1; end
            OP_LW:   begin c.reg_we = 1'b1; c.req_ram = 1'b1; end
            OP_SW:   begin c.req_ram = 1'b1; c.mem_we = 1'b1; end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/prco_decode_stage_if.sv
// Fetch-side and issue-side handshake plus the decoded bundle of the PRCO
// decode stage; slave is the stage itself, master is whoever drives it.
interface prco_decode_stage_if #(
    parameter int INSTR_W = 16,
    parameter int OP_W    = 5,
    parameter int REG_W   = 3,
    parameter int IMM_W   = 8,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16
);
    logic               i_valid;
    logic               q_ready;
    logic [INSTR_W-1:0] i_instr;
    logic               i_flush;
    logic               q_valid;
    logic               i_ready;
    logic [OP_W-1:0]    q_op;
    logic [REG_W-1:0]   q_seld;
    logic [REG_W-1:0]   q_sela;
    logic [IMM_W-1:0]   q_imm;
    logic [DATA_W-1:0]  q_simm;
    logic               q_reg_we;
    logic               q_req_alu;
    logic               q_req_ram;
    logic               q_mem_we;
    logic               q_illegal;
    logic [CNT_W-1:0]   q_dec_count;

    modport slave (
        input  i_valid, i_instr, i_flush, i_ready,
        output q_ready, q_valid, q_op, q_seld, q_sela, q_imm, q_simm,
               q_reg_we, q_req_alu, q_req_ram, q_mem_we, q_illegal, q_dec_count
    );

    modport master (
        output i_valid, i_instr, i_flush, i_ready,
        input  q_ready, q_valid, q_op, q_seld, q_sela, q_imm, q_simm,
               q_reg_we, q_req_alu, q_req_ram, q_mem_we, q_illegal, q_dec_count
    );

endinterface

// File: rtl/prco_decode_stage_skid_buf.sv
// prco_skid_buf: valid/ready payload buffer. With PRCO_DECODE_SKID_EN it is a
// 2-entry skid buffer with registered in_ready; otherwise a single register.
module prco_skid_buf
    import prco_decode_stage_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

`ifdef PRCO_DECODE_SKID_EN

    buf_state_e   state_q, state_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] skid_q, skid_d;
    logic         push, pop;

    assign in_ready  = (state_q != BUF_FULL);
    assign out_valid = (state_q != BUF_EMPTY);
    assign out_data  = out_q;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    // The skid entry always refills the output register before any new word.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (push) begin
                        out_d   = in_data;
                        state_d = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (push && pop) begin
                        out_d = in_data;
                    end else if (push) begin
                        skid_d  = in_data;
                        state_d = BUF_FULL;
                    end else if (pop) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (pop) begin
                        out_d   = skid_q;
                        state_d = BUF_ONE;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

`else

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         push;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign push      = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (push) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

`endif

endmodule

// File: rtl/prco_decode_stage.sv
// PRCO decode stage: field split, control decode, handshake buffering and an
// accept counter. Buffer depth selected by PRCO_DECODE_SKID_EN.
module prco_decode_stage
    import prco_decode_stage_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int OP_W    = 5,
    parameter int REG_W   = 3,
    parameter int IMM_W   = 8,
    parameter int SIMM_W  = 5,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    prco_decode_stage_if.slave bus
);

    localparam int PAY_W = OP_W + 2*REG_W + IMM_W + DATA_W + CTRL_W;

    logic [OP_W-1:0]   op_in;
    logic [REG_W-1:0]  seld_in;
    logic [REG_W-1:0]  sela_in;
    logic [IMM_W-1:0]  imm_in;
    logic [DATA_W-1:0] simm_in;
    ctrl_t             ctrl_in;
    ctrl_t             ctrl_out;
    logic [PAY_W-1:0]  pay_in;
    logic [PAY_W-1:0]  pay_out;
    logic              ready;
    logic              accept;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign op_in   = bus.i_instr[INSTR_W-1 -: OP_W];
    assign seld_in = bus.i_instr[INSTR_W-OP_W-1 -: REG_W];
    assign sela_in = bus.i_instr[INSTR_W-OP_W-2*REG_W +: REG_W];
    assign imm_in  = bus.i_instr[IMM_W-1:0];
    assign simm_in = {{(DATA_W-SIMM_W){bus.i_instr[SIMM_W-1]}}, bus.i_instr[SIMM_W-1:0]};
    assign ctrl_in = decode_ctrl(OPC_W'(op_in));
    assign pay_in  = {op_in, seld_in, sela_in, imm_in, simm_in, ctrl_in};

    prco_skid_buf #(
        .W (PAY_W)
    ) u_skid (
        .clk       (i_clk),
        .rst       (i_rst),
        .flush     (bus.i_flush),
        .in_valid  (bus.i_valid),
        .in_ready  (ready),
        .in_data   (pay_in),
        .out_valid (bus.q_valid),
        .out_ready (bus.i_ready),
        .out_data  (pay_out)
    );

    assign bus.q_ready = ready;
    assign {bus.q_op, bus.q_seld, bus.q_sela, bus.q_imm, bus.q_simm, ctrl_out} = pay_out;
    assign bus.q_reg_we  = ctrl_out.reg_we;
    assign bus.q_req_alu = ctrl_out.req_alu;
    assign bus.q_req_ram = ctrl_out.req_ram;
    assign bus.q_mem_we  = ctrl_out.mem_we;
    assign bus.q_illegal = ctrl_out.illegal;

    // Counts accepts, so words later discarded by a flush are still included.
    assign accept = bus.i_valid && ready && !bus.i_flush;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.q_dec_count = cnt_q;

endmodule

// File: doc/prco_decode_stage.md
# prco_decode_stage

- Parametrised instruction decode stage for the PRCO core, sitting between fetch and the register-file/ALU/RAM issue logic.
- Splits each instruction word into opcode, register selects and immediates, and produces a per-op control bundle.
- Adds what the first-generation decoder lacked: a valid/ready handshake on both sides, a 2-entry skid buffer, flush, illegal-op flagging and a decode counter.

## Interface
- INSTR_W, 16, instruction width
- OP_W, 5, opcode field width at [INSTR_W-1 -: OP_W]
- REG_W, 3, register select width; seld immediately below opcode, sela at [7:5] for default widths (generally [INSTR_W-OP_W-2*REG_W +: REG_W])
- IMM_W, 8, unsigned immediate at [IMM_W-1:0]
- SIMM_W, 5, signed immediate at [SIMM_W-1:0]
- DATA_W, 16, width of sign-extended immediate output
- CNT_W, 16, decode counter width

Ports (clock and reset first):
- i_clk  in  1  clock; single clock domain
- i_rst  in  1  reset; asynchronous, active-high
- i_valid  in  1  fetch presents i_instr
- q_ready  out  1  stage can accept
- i_instr  in  INSTR_W  instruction word
- i_flush  in  1  discard all held and incoming instructions
- q_valid  out  1  decoded bundle valid
- i_ready  in  1  issue stage accepts bundle
- q_op  out  OP_W  opcode
- q_seld, q_sela  out  REG_W  destination / source selects
- q_imm  out  IMM_W  zero-extended immediate field
- q_simm  out  DATA_W  sign-extended SIMM_W field
- q_reg_we, q_req_alu, q_req_ram, q_mem_we  out  1  control bundle
- q_illegal  out  1  opcode not in ISA table
- q_dec_count  out  CNT_W  instructions accepted since reset

## Operation
- Accept when i_valid && q_ready && !i_flush; emit when q_valid && i_ready.
- Control per op:
  - NOP: all zero.
  - MOVI: reg_we.
  - MOV: reg_we, req_alu.
  - ADD: reg_we, req_alu.
  - LW: reg_we, req_ram.
  - SW: req_ram, mem_we.
  - Any other opcode: all zero, q_illegal=1; still emitted, never dropped.
- Field outputs are always populated regardless of op.
- q_simm = {{(DATA_W-SIMM_W){i_instr[SIMM_W-1]}}, i_instr[SIMM_W-1:0]}.
- q_dec_count increments by 1 per accepted instruction, wraps to 0 at 2^CNT_W; flushed instructions still count if accepted before the flush.
- Flush: both buffer entries invalidated the same edge; input presented with i_flush is not accepted; q_ready=1 the cycle after.
- Reset mid-operation: all entries invalidated immediately (asynchronous), counter cleared.

## Timing
- Reset values:
  - q_valid=0, q_ready=1.
  - All bundle/field outputs 0, q_illegal=0, q_dec_count=0.
- Latency: an instruction accepted at edge N has q_valid=1 after edge N.
- Throughput: 1 instruction/cycle while i_ready=1.
- Buffer states: EMPTY → ONE (accept, no emit); ONE → ONE (accept+emit); ONE → FULL (accept, no emit); FULL → ONE (emit); any → EMPTY (flush).
- q_ready is registered: 0 only in FULL.
- Order is strictly preserved; the skid entry drains before any new word.
- Outputs are held stable while q_valid && !i_ready.

## Configuration
- PRCO_DECODE_SKID_EN defined: 2-entry skid buffer as above; q_ready has no combinational path from i_ready.
- Undefined: single output register, q_ready = !q_valid || i_ready (combinational), no FULL state; latency and throughput are unchanged.

## Structure
- Opcode constants (NOP, MOVI, MOV, ADD, LW, SW) and the control-bundle field layout live in the shared ISA include/package; the decode table is a function there.
- One sub-module, prco_skid_buf: parametrised by payload width; carries the decoded bundle; compiled per PRCO_DECODE_SKID_EN.

## Test plan
- Reset while FULL: q_valid=0, q_ready=1, q_dec_count=0 immediately, before the next edge.
- MOVI r3,0x5A with i_ready=1:
  - Next cycle: q_valid=1, q_seld=3, q_imm=0x5A, q_reg_we=1, q_req_ram=0.
  - q_dec_count=1.
- LW r2,-3(r1) (simm=5'b11101):
  - q_simm=16'hFFFD, q_sela=1, q_req_ram=1, q_reg_we=1.
- Back-pressure: stream 4 ADDs with i_ready held 0 for 3 cycles (SKID_EN):
  - q_ready falls after 2 accepts.
  - All 4 emerge in order once i_ready=1; none lost or duplicated.
- Opcode 5'h1F:
  - q_illegal=1, all control bits 0, q_dec_count increments.
- i_flush with FULL buffer and i_valid=1 the same cycle:
  - Next cycle q_valid=0, q_ready=1; the flushed input is never emitted.
  - Counter unchanged by the rejected word.
